// File: rtl/uart_pkg.sv
// Shared UART definitions, used by uart_tx now and by the future uart_rx.
// Contents:
//   uart_state_e        transmitter frame states
//   UART_IDLE_LEVEL     line level while idle and during stop bits
//   UART_START_LEVEL    line level of the start bit
//   UART_DATA_BITS_MIN/MAX  legal range of data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  localparam int UART_DATA_BITS_MIN = 5;
  localparam int UART_DATA_BITS_MAX = 9;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter. Takes bytes over a valid/ready handshake and shifts each
// out LSB first as: start bit, DATA_BITS data bits, optional parity bit,
// STOP_BITS stop bits. baud_tick (from the clock divider) is a one-cycle
// enable marking each bit boundary; the line register only changes on ticks.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// last data bit (even parity, or odd when PARITY_ODD=1). Without the macro the
// frame has no parity bit and PARITY_ODD is only range-checked.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset; aborts any frame, tx=1
//   baud_tick  one-cycle strobe per bit period
//   in_data    byte to send, sampled on accept (in_valid && in_ready)
//   in_valid   in_data is valid
//   in_ready   transmitter can accept a byte this cycle
//   tx         serial line, idle high
//   busy       a frame is pending or in flight
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int                IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  // Elaboration-time guard against unsupported frame shapes.
  if (DATA_BITS < UART_DATA_BITS_MIN || DATA_BITS > UART_DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     next_idx;
  logic                 stop_cnt;
  logic                 last_stop;
  logic                 accept;

  // The final stop bit is the only in-flight slot where a new byte may be
  // taken, which is what makes back-to-back frames gapless.
  assign last_stop = (state == ST_STOP) && (stop_cnt == STOP_LAST);
  assign in_ready  = (state == ST_IDLE) || last_stop;
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign next_idx  = bit_idx + 1'b1;

  // Data register: loaded only on accept and read by index, so in_data may
  // change freely while a frame is on the line.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= in_data;
    end
  end

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SEED = (PARITY_ODD != 0);
  logic parity_bit;

  // Parity is fixed at accept time from the latched byte.
  always_ff @(posedge clk) begin
    if (accept) begin
      parity_bit <= (^in_data) ^ PAR_SEED;
    end
  end
`endif

  // Frame FSM and line register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx       <= UART_IDLE_LEVEL;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        // A tick coinciding with accept is ignored here, so the start bit
        // always begins on a later tick.
        ST_IDLE: begin
          if (accept) begin
            state <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (baud_tick) begin
            tx    <= UART_START_LEVEL;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (baud_tick) begin
            tx      <= shreg[0];
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx != LAST_IDX) begin
              tx      <= shreg[next_idx];
              bit_idx <= next_idx;
            end else begin
`ifdef UART_TX_PARITY_EN
              tx       <= parity_bit;
              state    <= ST_PARITY;
`else
              tx       <= UART_IDLE_LEVEL;
              stop_cnt <= 1'b0;
              state    <= ST_STOP;
`endif
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            tx       <= UART_IDLE_LEVEL;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (accept) begin
            // New byte during the final stop bit: if the tick lands in the
            // same cycle the start bit goes out immediately, otherwise wait
            // in ARMED for the next tick. Either way no idle bit is added.
            if (baud_tick) begin
              tx    <= UART_START_LEVEL;
              state <= ST_START;
            end else begin
              state <= ST_ARMED;
            end
          end else if (baud_tick) begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          tx    <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Two instances run side by side from one
// tick stream: dut0 is 8 data bits / 1 stop, dut1 is 7 data bits / 2 stop
// (odd parity when UART_TX_PARITY_EN is defined). Each has its own byte FIFO
// driving its valid/ready handshake. The reference model represents a frame
// as a queue of line levels, one consumed per tick, and derives tx, busy and
// in_ready from that queue.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic [7:0] d0;
  logic [6:0] d1;
  logic       v0, v1;
  logic       r0, r1, tx0, tx1, b0, b1;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .in_data(d0),
    .in_valid(v0), .in_ready(r0), .tx(tx0), .busy(b0)
  );

  uart_tx #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .in_data(d1),
    .in_valid(v1), .in_ready(r1), .tx(tx1), .busy(b1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state, per instance.
  bit         mq     [2][$];   // line levels still to be sent, one per tick
  bit         m_busy [2];
  bit         m_line [2];
  logic [7:0] fifo   [2][$];   // bytes waiting to be offered
  int         acc    [2];
  bit         cap    [2][$];   // DUT tx captured after each model bit tick
  int         period;
  int         cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line levels of one frame, straight from the frame format.
  task automatic build_frame(input int k, input logic [7:0] w);
    int nb;
    int ns;
    logic [7:0] m;
    nb = (k == 0) ? 8 : 7;
    ns = (k == 0) ? 1 : 2;
    m  = (k == 0) ? 8'hFF : 8'h7F;
    mq[k].delete();
    mq[k].push_back(1'b0);
    for (int i = 0; i < nb; i++) mq[k].push_back(w[i]);
    if (PAR_EN) mq[k].push_back((^(w & m)) ^ (k == 1));
    for (int i = 0; i < ns; i++) mq[k].push_back(1'b1);
  endtask

  function automatic bit model_ready(input int k);
    // Idle, or in the last stop bit (nothing left to send but still busy).
    return !m_busy[k] || (mq[k].size() == 0);
  endfunction

  task automatic check_outputs();
    check("tx0",    tx0, m_line[0]);
    check("busy0",  b0,  m_busy[0]);
    check("ready0", r0,  model_ready(0));
    check("tx1",    tx1, m_line[1]);
    check("busy1",  b1,  m_busy[1]);
    check("ready1", r1,  model_ready(1));
  endtask

  // One clock cycle: drive inputs, clock, advance model, check.
  task automatic cycle();
    bit t;
    bit rdy [2];
    bit vk;
    bit acc_now;
    bit from_idle;
    logic [7:0] w;
    t = (period != 0) && (cyc % period == 0);
    cyc++;
    baud_tick = t;
    for (int k = 0; k < 2; k++) rdy[k] = model_ready(k);
    v0 = (fifo[0].size() != 0);
    d0 = v0 ? fifo[0][0] : 8'($urandom);
    v1 = (fifo[1].size() != 0);
    if (v1) begin
      w  = fifo[1][0];
      d1 = w[6:0];
    end else begin
      d1 = 7'($urandom);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      vk = (k == 0) ? v0 : v1;
      acc_now   = vk && rdy[k];
      from_idle = !m_busy[k];
      if (acc_now) begin
        w = fifo[k].pop_front();
        build_frame(k, w);
        m_busy[k] = 1'b1;
        acc[k]++;
      end
      if (t && !(acc_now && from_idle)) begin
        if (mq[k].size() != 0) begin
          m_line[k] = mq[k].pop_front();
          #0;
          cap[k].push_back(1'b0);  // slot filled with the sampled DUT level below
        end else if (m_busy[k]) begin
          m_busy[k] = 1'b0;
        end
      end
    end
    #1;
    // Fill the newest capture slots with what the DUT actually put on the line.
    if (cap[0].size() != 0 && t) cap[0][cap[0].size()-1] = tx0;
    if (cap[1].size() != 0 && t) cap[1][cap[1].size()-1] = tx1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((fifo[0].size() != 0 || fifo[1].size() != 0 || m_busy[0] || m_busy[1])
           && n < max_cycles) begin
      cycle();
      n++;
    end
    check({tag, "_drain_timeout"}, (n >= max_cycles), 1'b0);
    run(period + 2);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #2;
    v0 = 1'b0;
    v1 = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_tx0", tx0, 1'b1);
    check("rst_busy0", b0, 1'b0);
    check("rst_ready0", r0, 1'b1);
    check("rst_tx1", tx1, 1'b1);
    check("rst_busy1", b1, 1'b0);
    check("rst_ready1", r1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      fifo[k].delete();
      m_busy[k] = 1'b0;
      m_line[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_capture(input string tag, input int k, input logic [10:0] exp, input int len);
    check({tag, "_len"}, cap[k].size(), len);
    for (int i = 0; i < len && i < cap[k].size(); i++)
      check($sformatf("%s_bit%0d", tag, i), cap[k][i], exp[i]);
  endtask

  initial begin
    logic [10:0] e0;
    logic [10:0] e1;
    int l0;
    int l1;
    int a_before;
    int n;

    reset = 1'b1;
    baud_tick = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    d0 = '0;
    d1 = '0;
    period = 4;
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_line[k] = 1'b1;
      acc[k] = 0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx0", tx0, 1'b1);
    check("reset_busy0", b0, 1'b0);
    check("reset_ready0", r0, 1'b1);
    check("reset_tx1", tx1, 1'b1);
    check("reset_busy1", b1, 1'b0);
    check("reset_ready1", r1, 1'b1);
    reset = 1'b0;
    run(3);

    // Known frames: 0x55 on dut0, 0x7F on dut1; exact tick-by-tick levels.
    cap[0].delete();
    cap[1].delete();
    fifo[0].push_back(8'h55);
    fifo[1].push_back(8'h7F);
    drain("f55", 400);
    if (PAR_EN) begin
      e0 = 11'b10010101010; l0 = 11;  // parity(0x55) even = 0
      e1 = 11'b11011111110; l1 = 11;  // parity(0x7F) odd = 0
    end else begin
      e0 = 11'b01010101010; l0 = 10;
      e1 = 11'b01111111110; l1 = 10;
    end
    check_capture("frame55", 0, e0, l0);
    check_capture("frame7f", 1, e1, l1);

    // Parity value for 0x07 on dut0 (even): 1.
    cap[0].delete();
    fifo[0].push_back(8'h07);
    drain("f07", 400);
    if (PAR_EN) begin
      e0 = 11'b11000001110; l0 = 11;
    end else begin
      e0 = 11'b01000001110; l0 = 10;
    end
    check_capture("frame07", 0, e0, l0);

    // Back-to-back: second byte taken during the stop bit, no idle gap.
    cap[0].delete();
    fifo[0].push_back(8'hA5);
    fifo[0].push_back(8'h3C);
    fifo[1].push_back(8'h25);
    fifo[1].push_back(8'h3C);
    drain("b2b", 800);
    check("b2b_len0", cap[0].size(), PAR_EN ? 22 : 20);

    // Reset during data bit 3 of 0xF0, then a clean 0x81 frame.
    fifo[0].push_back(8'hF0);
    fifo[1].push_back(8'h70);
    n = 0;
    while (!(m_busy[0] && mq[0].size() == (PAR_EN ? 6 : 5)) && n < 200) begin
      cycle();
      n++;
    end
    check("rst_mid_timeout", (n >= 200), 1'b0);
    check("rst_mid_bit3", tx0, 1'b0);  // bit 3 of 0xF0
    do_reset();
    run(2);
    cap[0].delete();
    fifo[0].push_back(8'h81);
    fifo[1].push_back(8'h01);
    drain("after_rst", 400);
    if (PAR_EN) begin
      e0 = 11'b10100000010; l0 = 11;  // parity(0x81) even = 0
    end else begin
      e0 = 11'b01100000010; l0 = 10;
    end
    check_capture("frame81", 0, e0, l0);

    // Valid held with no ticks: exactly one accept, line stays idle.
    period = 0;
    a_before = acc[0];
    fifo[0].push_back(8'h12);
    fifo[0].push_back(8'h34);
    run(50);
    check("noticks_accepts", acc[0] - a_before, 1);
    check("noticks_tx", tx0, 1'b1);
    check("noticks_busy", b0, 1'b1);
    check("noticks_ready", r0, 1'b0);
    period = 4;
    drain("noticks", 800);

    // Random traffic, tick spacing and occasional mid-frame resets.
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) period = $urandom_range(2, 7);
      for (int k = 0; k < 2; k++)
        if (fifo[k].size() < 3 && $urandom_range(0, 5) == 0)
          fifo[k].push_back(8'($urandom));
      if ($urandom_range(0, 1999) == 0) do_reset();
      else cycle();
    end
    drain("random", 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
